// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared operation codes, FSM state encoding and op-class helpers
// for the HI/LO multiply-divide unit and its iterative divider.
package muldiv_pkg;

    localparam logic [3:0] MD_MULT  = 4'd0;
    localparam logic [3:0] MD_MULTU = 4'd1;
    localparam logic [3:0] MD_DIV   = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_MTHI  = 4'd4;
    localparam logic [3:0] MD_MTLO  = 4'd5;
    localparam logic [3:0] MD_MADD  = 4'd6;
    localparam logic [3:0] MD_MADDU = 4'd7;
    localparam logic [3:0] MD_MSUB  = 4'd8;
    localparam logic [3:0] MD_MSUBU = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    // Ops that go through the multiplier / accumulator path.
    function automatic logic is_mul_op(input logic [3:0] o);
        return o inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
    endfunction

    // Multiplier ops that treat their operands as two's complement.
    function automatic logic is_signed_mul(input logic [3:0] o);
        return o inside {MD_MULT, MD_MADD, MD_MSUB};
    endfunction

endpackage

// File: rtl/muldiv_unit_iter_divider.sv
// iter_divider: restoring divider, one quotient bit per clock on operand
// magnitudes, followed by one sign-fix cycle during which done=1 and the
// signed quot/rem are presented combinationally for the parent to capture.
//   clk, reset       clock, asynchronous active-high reset
//   go               load operands and begin (parent guarantees divisor != 0)
//   flush            abandon the current division
//   is_signed        operands are two's complement (sampled with go)
//   dividend/divisor W-bit operands (sampled with go)
//   done             high for the single cycle after the last iteration
//   quot/rem         quotient truncated toward zero, remainder signed as dividend
module iter_divider
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    input  logic         flush,
    input  logic         is_signed,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem
);
    localparam int CW = $clog2(W);

    logic          run_q, run_d;
    logic          fix_q, fix_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic          neg_quo_q, neg_quo_d;
    logic          neg_rem_q, neg_rem_d;

    logic [W:0]    shifted;
    logic          borrow;
    logic [W-1:0]  diff;

    // Partial remainder shifted left with the next dividend bit. When the
    // trial subtraction does not borrow the true difference is below the
    // divisor, so the W-bit modular difference is exact.
    assign shifted = {rem_q, quo_q[W-1]};
    assign borrow  = shifted < {1'b0, dvs_q};
    assign diff    = shifted[W-1:0] - dvs_q;

    always_comb begin
        run_d     = run_q;
        fix_d     = fix_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (flush) begin
            run_d = 1'b0;
            fix_d = 1'b0;
        end else if (go) begin
            run_d     = 1'b1;
            fix_d     = 1'b0;
            cnt_d     = '0;
            rem_d     = '0;
            // The magnitude of the most negative value wraps to itself, which
            // is its correct unsigned magnitude.
            quo_d     = (is_signed && dividend[W-1]) ? -dividend : dividend;
            dvs_d     = (is_signed && divisor[W-1])  ? -divisor  : divisor;
            neg_quo_d = is_signed && (dividend[W-1] ^ divisor[W-1]);
            neg_rem_d = is_signed && dividend[W-1];
        end else if (run_q) begin
            rem_d = borrow ? shifted[W-1:0] : diff;
            quo_d = {quo_q[W-2:0], ~borrow};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                run_d = 1'b0;
                fix_d = 1'b1;
            end
        end else if (fix_q) begin
            fix_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q     <= 1'b0;
            fix_q     <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            run_q     <= run_d;
            fix_q     <= fix_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign done = fix_q;
    assign quot = neg_quo_q ? -quo_q : quo_q;
    assign rem  = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply / multiply-accumulate / divide unit for EX.
//   clk, reset  clock, asynchronous active-high reset
//   start, op   launch an MD_* operation (taken only while busy==0)
//   a, b        rs / rt operands
//   cancel      abort the in-flight operation, hi/lo untouched
//   busy        operation in flight
//   hi, lo      architectural HI / LO registers
//   div_zero    one-cycle pulse when a DIV/DIVU by zero writes back
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int W       = 32,
    parameter int MUL_LAT = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cancel,
    output logic         busy,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         div_zero
);
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    md_state_e      state_q, state_d;
    logic           busy_q, busy_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           dz_q, dz_d;
    logic [3:0]     op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           dz_pend_q, dz_pend_d;
    logic [2*W-1:0] prod_q, prod_d;

    logic [2*W-1:0] a_ext, b_ext, prod_now, acc, wb_val;
    logic           div_go, div_flush, div_done;
    logic [W-1:0]   div_quot, div_rem;

    // Extending to 2W bits before multiplying gives the signed or unsigned
    // product exactly in the low 2W bits.
    assign a_ext    = is_signed_mul(op) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    assign b_ext    = is_signed_mul(op) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    assign prod_now = a_ext * b_ext;
    assign acc      = {hi_q, lo_q};

    always_comb begin
        unique case (op_q)
            MD_MADD, MD_MADDU: wb_val = acc + prod_q;
            MD_MSUB, MD_MSUBU: wb_val = acc - prod_q;
            default:           wb_val = prod_q;
        endcase
    end

    assign div_flush = cancel && (state_q == ST_DIV);

    iter_divider #(.W(W)) u_div (
        .clk       (clk),
        .reset     (reset),
        .go        (div_go),
        .flush     (div_flush),
        .is_signed (op == MD_DIV),
        .dividend  (a),
        .divisor   (b),
        .done      (div_done),
        .quot      (div_quot),
        .rem       (div_rem)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = 1'b0;
        op_d      = op_q;
        cnt_d     = cnt_q;
        dz_pend_d = dz_pend_q;
        prod_d    = prod_q;
        div_go    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_mul_op(op)) begin
                        state_d = ST_MUL;
                        busy_d  = 1'b1;
                        op_d    = op;
                        cnt_d   = CW'(MUL_LAT - 1);
                        prod_d  = prod_now;
                    end else if (op == MD_DIV || op == MD_DIVU) begin
                        state_d = ST_DIV;
                        busy_d  = 1'b1;
                        op_d    = op;
                        if (b == '0) begin
                            // Zero divisor skips the divider; the product
                            // register parks the dividend for the HI write.
                            dz_pend_d = 1'b1;
                            prod_d    = {{W{1'b0}}, a};
                        end else begin
                            dz_pend_d = 1'b0;
                            div_go    = 1'b1;
                        end
                    end else if (op == MD_MTHI) begin
                        hi_d = a;
                    end else if (op == MD_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_MUL: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    hi_d    = wb_val[2*W-1:W];
                    lo_d    = wb_val[W-1:0];
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DIV: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (dz_pend_q) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    dz_pend_d = 1'b0;
                    hi_d      = prod_q[W-1:0];
                    lo_d      = '1;
                    dz_d      = 1'b1;
                end else if (div_done) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    hi_d    = div_rem;
                    lo_d    = div_quot;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
            op_q      <= '0;
            cnt_q     <= '0;
            dz_pend_q <= 1'b0;
            prod_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dz_q      <= dz_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            dz_pend_q <= dz_pend_d;
            prod_q    <= prod_d;
        end
    end

    assign busy     = busy_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit (W=32, MUL_LAT=5).
// Stimulus pushes the expected hi/lo/div_zero of every busy operation into a
// queue; a monitor pops and compares whenever busy falls.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        cancel;
    logic        busy;
    logic [31:0] hi, lo;
    logic        div_zero;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;
    exp_t exp_q[$];

    muldiv_unit #(.W(32), .MUL_LAT(5)) dut (
        .clk      (clk),
        .reset    (rst),
        .start    (start),
        .op       (op_i),
        .a        (a_i),
        .b        (b_i),
        .cancel   (cancel),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] eh, input logic [31:0] el, input logic ed);
        exp_t e;
        e.hi = eh;
        e.lo = el;
        e.dz = ed;
        exp_q.push_back(e);
    endtask

    // Monitor: every busy 1->0 transition outside reset is a retirement.
    initial begin : monitor
        logic busy_prev;
        exp_t e;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_prev = 1'b0;
            end else begin
                if (busy_prev && !busy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_retire: got hi=%h lo=%h expected no retirement", hi, lo);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wb_hi", hi, e.hi);
                        chk("wb_lo", lo, e.lo);
                        chk("wb_div_zero", {31'b0, div_zero}, {31'b0, e.dz});
                    end
                end
                busy_prev = busy;
            end
        end
    end

    // Wait for busy to drop, counting cycles it was high (bounded).
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still high after %0d cycles", n);
        end
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eh, input logic [31:0] el, input logic ed,
                          input int eb);
        int n;
        $display("op=%0d a=%h b=%h expect hi=%h lo=%h dz=%0d busy=%0d", o, av, bv, eh, el, ed, eb);
        if (eb > 0) push_exp(eh, el, ed);
        @(negedge clk);
        op_i = o; a_i = av; b_i = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        chk("busy_cycles", n, eb);
        if (eb == 0) begin
            chk("direct_hi", hi, eh);
            chk("direct_lo", lo, el);
        end
    endtask

    initial begin : stim
        int n;
        rst = 1'b1; start = 1'b0; cancel = 1'b0; op_i = '0; a_i = '0; b_i = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_div_zero", {31'b0, div_zero}, 32'd0);

        // Multiply and accumulate variants.
        run_op(MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 5);
        run_op(MD_MTHI,  32'd0,        32'd0,        32'h00000000, 32'hFFFFFFFA, 1'b0, 0);
        run_op(MD_MTLO,  32'd10,       32'd0,        32'h00000000, 32'h0000000A, 1'b0, 0);
        run_op(MD_MADDU, 32'hFFFFFFFF, 32'd2,        32'h00000002, 32'h00000008, 1'b0, 5);
        run_op(MD_MSUB,  32'd3,        32'hFFFFFFFF, 32'h00000002, 32'h0000000B, 1'b0, 5);
        run_op(MD_MSUBU, 32'd1,        32'h0000000C, 32'h00000001, 32'hFFFFFFFF, 1'b0, 5);
        run_op(MD_MADD,  32'hFFFFFFFF, 32'd1,        32'h00000001, 32'hFFFFFFFE, 1'b0, 5);
        run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 5);

        // Division, signed and unsigned, including overflow and zero divisor.
        run_op(MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
        run_op(MD_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 33);
        run_op(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33);
        run_op(MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33);
        run_op(MD_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1, 1);
        @(negedge clk);
        chk("div_zero_pulse_end", {31'b0, div_zero}, 32'd0);
        run_op(MD_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, 33);

        // Unknown op code is ignored.
        run_op(4'd12,    32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'hFFFFFFFF, 1'b0, 0);

        // Cancel a running divide at cycle 10: hi/lo must keep prior values.
        $display("op=%0d a=%h b=%h cancel at cycle 10", MD_DIV, 32'd100, 32'd3);
        push_exp(32'h00000000, 32'hFFFFFFFF, 1'b0);
        @(negedge clk);
        op_i = MD_DIV; a_i = 32'd100; b_i = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", {31'b0, busy}, 32'd0);
        run_op(MD_MULT,  32'd3,        32'd4,        32'h00000000, 32'h0000000C, 1'b0, 5);

        // Cancel on the writeback edge: no writeback.
        $display("op=%0d a=%h b=%h cancel on writeback edge", MD_MULT, 32'd9, 32'd9);
        push_exp(32'h00000000, 32'h0000000C, 1'b0);
        @(negedge clk);
        op_i = MD_MULT; a_i = 32'd9; b_i = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_wb_busy", {31'b0, busy}, 32'd0);

        // Start while busy is ignored (an MTHI would otherwise clobber hi).
        $display("op=%0d a=%h b=%h with MTHI start while busy", MD_MULT, 32'd2, 32'd3);
        push_exp(32'h00000000, 32'h00000006, 1'b0);
        @(negedge clk);
        op_i = MD_MULT; a_i = 32'd2; b_i = 32'd3; start = 1'b1;
        @(negedge clk);
        op_i = MD_MTHI; a_i = 32'hDEADBEEF; b_i = 32'd0;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        chk("busy_cycles_ignored_start", n + 1, 32'd5);

        // Cancel while idle does not block a same-cycle start.
        $display("op=%0d a=%h b=%h with cancel while idle", MD_MULT, 32'd5, 32'd5);
        push_exp(32'h00000000, 32'h00000019, 1'b0);
        @(negedge clk);
        op_i = MD_MULT; a_i = 32'd5; b_i = 32'd5; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        wait_idle(n);
        chk("busy_cycles_idle_cancel", n, 32'd5);

        // Asynchronous reset mid-multiply clears state without a clock edge.
        $display("op=%0d a=%h b=%h async reset mid-op", MD_MULT, 32'd7, 32'd7);
        @(negedge clk);
        op_i = MD_MULT; a_i = 32'd7; b_i = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_busy", {31'b0, busy}, 32'd0);
        chk("async_reset_hi", hi, 32'd0);
        chk("async_reset_lo", lo, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_reset_busy", {31'b0, busy}, 32'd0);
        chk("post_reset_lo", lo, 32'd0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
